// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 16-bit CPU.
// Owns the program counter and the instruction register. Fetches words from
// instruction memory over a req/ack handshake and drives the decoder INST
// input. Generates the one-cycle register read (EXEC) and write (WB) strobes.
// All strobes are registered Moore outputs decoded from the next state, so
// they never depend combinationally on the inputs. The asynchronous reset
// clears them immediately.
module cpu_sequencer #(
    parameter int         PC_W     = 8,
    parameter logic [3:0] OP_LOADI = 4'h1,
    parameter logic [3:0] OP_ADD   = 4'h2,
    parameter logic [3:0] OP_SUB   = 4'h3
) (
    input  logic            clk,
    input  logic            res,
    input  logic            run,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [15:0]     inst,
    output logic            reg_rd_en,
    output logic            reg_wr_en,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;

    // Only these three opcodes are executable; anything else traps to HALT.
    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_LOADI) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Register-to-register operations read two sources; LOADI reads none.
    function automatic logic reads_regs(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Program counter advance, wrapping naturally at 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
        return p + PC_W'(1);
    endfunction

    // Retired-instruction counter advance, wrapping at 16'hFFFF.
    function automatic logic [15:0] ret_inc(input logic [15:0] r);
        return r + 16'd1;
    endfunction

    assign imem_addr = pc;

    // Next-state selection; run is only looked at in IDLE and WB.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = FETCH;
            FETCH:   if (imem_ack) state_nxt = DECODE;
            DECODE:  state_nxt = is_legal(inst[15:12]) ? EXEC : HALT;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = run ? FETCH : IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, architectural registers and registered Moore strobes.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            pc        <= '0;
            inst      <= 16'h0000;
            retired   <= 16'h0000;
            err       <= 1'b0;
            imem_req  <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_wr_en <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state <= state_nxt;

            // Capture only on an ack inside FETCH; inst then holds until
            // the next capture, so it is stable from DECODE through WB.
            if (state == FETCH && imem_ack) begin
                inst <= imem_data;
            end

            // Illegal opcode: sticky flag, pc and retired left untouched.
            if (state == DECODE && !is_legal(inst[15:12])) begin
                err <= 1'b1;
            end

            // Commit point of an instruction is the edge leaving WB.
            if (state == WB) begin
                pc      <= pc_inc(pc);
                retired <= ret_inc(retired);
            end

            // Strobes are decoded from the state being entered, so they are
            // valid for exactly the cycle spent in that state. In DECODE the
            // captured inst is already stable, so the read strobe for EXEC
            // can be qualified by its opcode here.
            imem_req  <= (state_nxt == FETCH);
            reg_rd_en <= (state_nxt == EXEC) && reads_regs(inst[15:12]);
            reg_wr_en <= (state_nxt == WB);
            busy      <= (state_nxt != IDLE) && (state_nxt != HALT);
            halted    <= (state_nxt == HALT);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: randomized memory latency and programs,
// instruction-level reference model, scoreboard checked on every WB strobe.
module tb_cpu_sequencer;

    localparam logic [3:0] OP_LOADI = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        run = 1'b1;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] inst;
    logic        reg_rd_en;
    logic        reg_wr_en;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    cpu_sequencer #(
        .PC_W(8), .OP_LOADI(OP_LOADI), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)
    ) dut (
        .clk(clk), .res(res), .run(run), .imem_ack(imem_ack),
        .imem_data(imem_data), .imem_req(imem_req), .imem_addr(imem_addr),
        .inst(inst), .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
        .busy(busy), .halted(halted), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] iw;
        bit          rd;
        logic [15:0] ret;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [256];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          resp_mode = 0;   // 0 normal, 2 ack stuck high with junk data
    int          wait_mode = 0;   // 0 zero-wait, 1 random 0..3 waits
    bit          force_en = 0;
    logic [7:0]  force_pc = 8'h00;
    int          force_wait = 0;
    int          ill_ack_cyc = -100;
    int          halt_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rand_legal();
        logic [3:0] op;
        case ($urandom_range(0, 2))
            0:       op = OP_LOADI;
            1:       op = OP_ADD;
            default: op = OP_SUB;
        endcase
        return {op, 12'($urandom)};
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder plus reference model: each accepted fetch of a legal
    // word predicts one retirement at the model's own pc/retired counters.
    logic [7:0]  m_pc = 8'h00;
    logic [15:0] m_ret = 16'h0000;
    bit          pending = 0;
    int          wcnt = 0;
    int          w0 = 0;
    logic [15:0] inst_hold = 16'h0000;
    logic [3:0]  mop;
    always @(negedge clk) begin
        if (!res) begin
            imem_ack = 1'b0;
            pending  = 0;
            m_pc     = 8'h00;
            m_ret    = 16'h0000;
            sb.delete();
        end else if (resp_mode == 2) begin
            imem_ack  = 1'b1;
            imem_data = 16'hF000;
        end else if (imem_req) begin
            if (!pending) begin
                pending = 1;
                w0 = (wait_mode == 1) ? int'($urandom_range(0, 3)) : 0;
                if (force_en && m_pc == force_pc) begin
                    w0 = force_wait;
                    force_en = 0;
                end
                wcnt = w0;
                inst_hold = inst;
                check("fetch_addr", imem_addr, m_pc);
            end else begin
                check("inst_hold_wait", inst, inst_hold);
            end
            if (wcnt == 0) begin
                imem_ack  = 1'b1;
                imem_data = mem[m_pc];
                mop = mem[m_pc][15:12];
                if (mop == OP_LOADI || mop == OP_ADD || mop == OP_SUB) begin
                    sb.push_back('{m_pc, mem[m_pc], (mop != OP_LOADI), m_ret, w0 + 4});
                    m_pc  = m_pc + 8'd1;
                    m_ret = m_ret + 16'd1;
                end else begin
                    ill_ack_cyc = cyc;
                end
            end else begin
                imem_ack = 1'b0;
                wcnt--;
            end
        end else begin
            imem_ack = 1'b0;
            pending  = 0;
        end
    end

    // Monitor: on every write-back strobe pop the oldest prediction.
    bit   rd_seen = 0;
    bit   prev_req = 0;
    bit   prev_halt = 0;
    int   st_cyc = 0;
    exp_t e;
    always @(negedge clk) begin
        if (!res) begin
            rd_seen   = 0;
            prev_req  = 0;
            prev_halt = 0;
        end else begin
            if (imem_req && !prev_req) st_cyc = cyc;
            if (reg_rd_en) rd_seen = 1;
            if (halted && !prev_halt) halt_cyc = cyc;
            if (reg_wr_en) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wb_unexpected: write-back at pc %0h with no predicted instruction", imem_addr);
                end else begin
                    e = sb.pop_front();
                    check("wb_pc", imem_addr, e.pc);
                    check("wb_inst", inst, e.iw);
                    check("wb_rd_strobe", rd_seen, e.rd);
                    check("wb_retired", retired, e.ret);
                    check("wb_cycles", cyc - st_cyc + 1, e.cycles);
                    check("wb_rd_clear", reg_rd_en, 0);
                end
                rd_seen = 0;
            end
            prev_req  = imem_req;
            prev_halt = halted;
        end
    end

    task automatic do_reset(input logic run_v);
        @(negedge clk);
        res = 1'b0;
        run = run_v;
        repeat (2) @(negedge clk);
        res = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_fetch_at(input string name, input logic [7:0] a);
        int n = 0;
        @(negedge clk);
        while (!(imem_req && imem_addr == a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, imem_req && imem_addr == a, 1);
    endtask

    task automatic wait_retired(input string name, input logic [15:0] r, input int limit);
        int n = 0;
        while (retired != r && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, retired, r);
    endtask

    initial begin
        int n;
        bit bad;
        mem[0] = {OP_LOADI, 3'b001, 9'h006};
        mem[1] = {OP_LOADI, 3'b010, 9'h003};
        mem[2] = {OP_ADD, 3'b011, 3'b001, 3'b010, 3'b000};
        mem[3] = {OP_SUB, 3'b011, 3'b011, 3'b001, 3'b000};
        for (int i = 4; i < 256; i++) mem[i] = rand_legal();

        // Reset held with run=1: everything quiet.
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_inst", inst, 0);
        check("rst_rd_en", reg_rd_en, 0);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_retired", retired, 0);

        // Zero-wait program: first fetch one edge after release, 4 cycles each.
        @(negedge clk);
        res = 1'b1;
        @(posedge clk); #1;
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
        repeat (16) @(posedge clk);
        #1;
        check("zw_retired16", retired, 4);
        check("zw_pc16", imem_addr, 4);
        run = 1'b0;
        wait_idle("zw_idle");

        // Wait states on the fetch at pc=2.
        force_pc = 8'h02; force_wait = 3; force_en = 1;
        do_reset(1'b1);
        wait_fetch_at("ws_reach_pc2", 8'h02);
        n = 0;
        while (imem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("ws_req_cycles", n, 4);
        wait_retired("ws_retired", 16'd4, 100);
        run = 1'b0;
        wait_idle("ws_idle");

        // Stop: drop run during EXEC of the instruction at pc=1.
        do_reset(1'b1);
        repeat (7) @(posedge clk);
        #1;
        run = 1'b0;
        @(posedge clk); #1;
        check("stop_wb_pulse", reg_wr_en, 1);
        @(posedge clk); #1;
        check("stop_busy", busy, 0);
        check("stop_pc", imem_addr, 2);
        check("stop_retired", retired, 2);
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (imem_req) n++;
        end
        check("stop_no_req", n, 0);
        run = 1'b1;
        @(posedge clk); #1;
        check("resume_req", imem_req, 1);
        check("resume_addr", imem_addr, 2);
        run = 1'b0;
        wait_idle("resume_idle");

        // Illegal opcode at pc=5 with random memory latency.
        mem[5] = {4'hF, 12'($urandom)};
        wait_mode = 1;
        do_reset(1'b1);
        n = 0;
        while (!halted && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("ill_halted", halted, 1);
        check("ill_err", err, 1);
        check("ill_pc", imem_addr, 5);
        check("ill_retired", retired, 5);
        check("ill_busy", busy, 0);
        @(negedge clk); #1;
        check("ill_latency", halt_cyc - ill_ack_cyc, 2);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            @(posedge clk); #1;
            if (!halted || !err || busy || imem_req || reg_rd_en || reg_wr_en ||
                imem_addr != 8'h05 || retired != 16'd5) bad = 1;
        end
        check("ill_sticky", bad, 0);
        mem[5] = rand_legal();

        // Random program long enough to wrap the 8-bit pc.
        for (int i = 0; i < 256; i++) mem[i] = rand_legal();
        do_reset(1'b1);
        wait_retired("wrap_retired", 16'd256, 4000);
        check("wrap_pc", imem_addr, 0);
        wait_retired("wrap_retired257", 16'd257, 100);
        run = 1'b0;
        wait_idle("wrap_idle");

        // Asynchronous reset mid-fetch, then a stray ack while idle.
        wait_mode = 0;
        force_pc = 8'h01; force_wait = 6; force_en = 1;
        do_reset(1'b1);
        wait_fetch_at("ar_reach_pc1", 8'h01);
        #2;
        res = 1'b0;
        run = 1'b0;
        #1;
        check("ar_req_drop", imem_req, 0);
        check("ar_busy_drop", busy, 0);
        check("ar_pc_clear", imem_addr, 0);
        resp_mode = 2;
        repeat (2) @(negedge clk);
        res = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ar_late_ack_inst", inst, 0);
        check("ar_late_ack_busy", busy, 0);
        check("ar_late_ack_err", err, 0);
        resp_mode = 0;
        @(negedge clk);
        #1;
        run = 1'b1;
        wait_retired("ar_restart_retired", 16'd2, 100);
        check("ar_restart_pc", imem_addr, 2);
        run = 1'b0;
        wait_idle("ar_idle");
        @(negedge clk); #1;
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
